// File: rtl/stuffed_frame_tx.sv
// Zero-stuffing serial frame transmitter: payload MSB first, a 0 after every run of three 1s,
// then a 0 separator and a 4-ones end flag. All line outputs (out_bit/busy/done) are registered together.
module stuffed_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             out_bit,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, DATA, STUFF, SEP, FLAG} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [1:0]       run, run_nxt;
  logic [1:0]       flag_cnt, flag_cnt_nxt;
  logic             bit_nxt, busy_nxt, done_nxt;
  logic             cur_bit;

  assign ready   = (state == IDLE);
  assign cur_bit = shreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      run      <= '0;
      flag_cnt <= '0;
      out_bit  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      run      <= run_nxt;
      flag_cnt <= flag_cnt_nxt;
      out_bit  <= bit_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // The state names the bit being produced this cycle; it reaches out_bit on the next edge.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    run_nxt      = run;
    flag_cnt_nxt = flag_cnt;
    bit_nxt      = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt    = data_in;
          bit_cnt_nxt  = '0;
          run_nxt      = '0;
          flag_cnt_nxt = '0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        bit_nxt     = cur_bit;
        busy_nxt    = 1'b1;
        shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + CW'(1);
        if (cur_bit) run_nxt = (run == 2'd3) ? 2'd3 : run + 2'd1;
        else         run_nxt = 2'd0;
        // No stuff after the final payload bit: the separator already supplies the 0.
        if (bit_cnt == LAST_BIT)               state_nxt = SEP;
        else if (cur_bit && run_nxt == 2'd3)   state_nxt = STUFF;
      end
      STUFF: begin
        busy_nxt  = 1'b1;
        run_nxt   = 2'd0;
        state_nxt = DATA;
      end
      SEP: begin
        busy_nxt     = 1'b1;
        run_nxt      = 2'd0;
        flag_cnt_nxt = 2'd0;
        state_nxt    = FLAG;
      end
      FLAG: begin
        bit_nxt      = 1'b1;
        busy_nxt     = 1'b1;
        flag_cnt_nxt = flag_cnt + 2'd1;
        if (flag_cnt == 2'd3) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stuffed_frame_tx.sv
// Directed and randomised checks of stuffed_frame_tx against hand-derived line sequences and a 4-ones detector model.
module tb_stuffed_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, out_bit, busy, done;
  logic [3:0] hist = 4'b0000;
  int         total = 0;
  int         bad = 0;

  stuffed_frame_tx #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .ready(ready), .out_bit(out_bit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Far-end consecutive-ones detector: history of bits already on the line.
  always @(negedge clk) hist <= {hist[2:0], out_bit};

  function automatic logic det_now();
    return &{hist[2:0], out_bit};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples len line cycles, expecting exp[len-1] first.
  task automatic run_bits(input string tag, input logic [31:0] exp, input int len);
    for (int i = 0; i < len; i++) begin
      tick();
      check($sformatf("%s_bit%0d", tag, i), 32'(out_bit), 32'(exp[len-1-i]));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s_done%0d", tag, i), 32'(done), (i == len-1) ? 32'd1 : 32'd0);
      check($sformatf("%s_det%0d", tag, i), 32'(det_now()), (i == len-1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic idle_check(input string tag);
    tick();
    check({tag, "_out"}, 32'(out_bit), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rdy"}, 32'(ready), 32'd1);
  endtask

  task automatic launch(input string tag, input logic [7:0] d);
    data_in = d;
    start   = 1'b1;
    check({tag, "_rdy_pre"}, 32'(ready), 32'd1);
    tick();
    start = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic [31:0] exp, input int len);
    launch(tag, d);
    run_bits(tag, exp, len);
    idle_check({tag, "_gap"});
  endtask

  initial begin
    tick();
    tick();
    check("rst_out", 32'(out_bit), 32'd0);
    check("rst_rdy", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    idle_check("idle0");

    frame("a5", 8'hA5, 32'(13'b1010010101111), 13);
    frame("ff", 8'hFF, 32'(15'b111011101101111), 15);
    frame("z0", 8'h00, 32'(13'b0000000001111), 13);

    // Back-to-back with start held; data change during busy must be ignored.
    launch("b2b", 8'hE7);
    start   = 1'b1;
    data_in = 8'h77;
    #1;
    check("b2b_rdy_busy", 32'(ready), 32'd0);
    run_bits("e7", 32'(14'b11100011101111), 14);
    tick();
    check("b2b_gap_out", 32'(out_bit), 32'd0);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    check("b2b_gap_rdy", 32'(ready), 32'd0);
    data_in = 8'h00;
    run_bits("s77", 32'(14'b01110011101111), 14);
    start = 1'b0;
    idle_check("b2b_end");
    idle_check("b2b_end2");

    // Reset in the middle of an all-ones payload.
    launch("mid", 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_bit%0d", i), 32'(out_bit), 32'd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_out", 32'(out_bit), 32'd0);
    check("mid_rst_rdy", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) idle_check($sformatf("mid_idle%0d", i));
    frame("a5b", 8'hA5, 32'(13'b1010010101111), 13);

    // Random payloads: de-stuff the line and count detector pulses.
    for (int f = 0; f < 12; f++) begin
      automatic logic [7:0] d = 8'($urandom);
      automatic logic [7:0] rx = 8'h00;
      automatic int nrx = 0, run = 0, stuffs = 0, len = 0, pulses = 0, tail = 0;
      automatic bit got_done = 0;
      launch($sformatf("r%0d", f), d);
      for (int c = 0; c < 40 && !got_done; c++) begin
        tick();
        if (busy) begin
          len++;
          if (nrx < 8) begin
            if (run == 3 && out_bit == 1'b0) begin
              stuffs++;
              run = 0;
            end else begin
              rx  = {rx[6:0], out_bit};
              nrx++;
              run = out_bit ? run + 1 : 0;
            end
          end else begin
            tail = {tail[30:0], out_bit};
          end
        end
        if (det_now()) pulses++;
        check($sformatf("r%0d_det_done%0d", f, c), 32'(det_now()), 32'(done));
        if (done) got_done = 1;
      end
      check($sformatf("r%0d_done_seen", f), 32'(got_done), 32'd1);
      check($sformatf("r%0d_payload", f), 32'(rx), 32'(d));
      check($sformatf("r%0d_tail", f), 32'(tail), 32'b01111);
      check($sformatf("r%0d_len", f), 32'(len), 32'(8 + stuffs + 5));
      check($sformatf("r%0d_pulses", f), 32'(pulses), 32'd1);
      idle_check($sformatf("r%0d_gap", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stuffed_frame_tx.md
Name: stuffed_frame_tx

Overview:
- Serial frame transmitter that feeds the consecutive-ones detector link.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clk.
- Zero-stuffs the payload so the payload and separator never contain four consecutive 1s, then ends each frame with a 4-ones end flag.
- The far-end detector fires exactly once per frame, on the last flag bit.

Parameters:
- WIDTH, 8, payload bits per frame (legal range 2..32).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send data_in; accepted only when ready=1.
- data_in  input  WIDTH  payload word, sampled on the accepting edge.
- ready  output  1  high only in IDLE; start&&ready is a transfer.
- out_bit  output  1  registered serial line output.
- busy  output  1  high while a frame is on the line (DATA, STUFF, SEP, FLAG).
- done  output  1  one-cycle pulse, coincident with the 4th flag bit on out_bit.

Behaviour:
- Reset, applied synchronously: state=IDLE, out_bit=0, ready=1 from the first cycle after reset, busy=0, done=0. All counters and the shift register clear.
- Reset mid-frame: the frame is abandoned. Next cycle out_bit=0, state=IDLE, and no done pulse is issued.
- States: IDLE, DATA, STUFF, SEP, FLAG.
- IDLE:
  - out_bit=0.
  - On start&&ready, latch data_in, clear bit counter and ones-run counter, go to DATA.
  - start while not ready is ignored; there is no queuing.
- DATA:
  - Each cycle out_bit = current payload bit (MSB first); bit counter increments.
  - The ones-run counter (0..3) increments on a 1 and clears on a 0.
  - If the emitted bit makes the run 3 and payload bits remain, next state is STUFF.
  - After the last payload bit, next state is SEP, regardless of run.
  - Otherwise stay in DATA.
- STUFF: out_bit=0 for one cycle; clear run; return to DATA with the next payload bit.
- SEP:
  - out_bit=0 for one cycle; go to FLAG.
  - SEP is always emitted, even if the last payload bit was 0 or the run is 3.
  - Purpose: guarantees the flag is preceded by a 0.
- FLAG:
  - out_bit=1 for exactly 4 cycles.
  - done=1 in the 4th cycle.
  - Then go to IDLE.
- Timing:
  - If the transfer happens at edge N, the first payload bit is on out_bit from edge N+1.
  - Frame length on the line = WIDTH + stuff_count + 1 + 4 cycles.
  - busy=1 for exactly those cycles.
- Inter-frame gap:
  - ready rises in the first IDLE cycle after FLAG.
  - That IDLE cycle always drives out_bit=0, even if start is already asserted.
  - Minimum gap between frames is one 0 bit; back-to-back frames are otherwise allowed.
- Invariant: no 4 consecutive 1s ever appear on out_bit except the flag.
  - Stuffing applies only between payload bits; no stuff bit is inserted after the final payload bit, since SEP covers it.
- Width rules:
  - Bit counter is $clog2(WIDTH+1) bits.
  - Flag counter is 2 bits.
  - Ones-run counter saturates at 3 and never wraps.

Test Plan:
- Reset then data_in=8'hA5, start=1 for one cycle.
  - Required out_bit from the next cycle: 1,0,1,0,0,1,0,1,0,1,1,1,1, then 0.
  - busy high 13 cycles; done on the 13th; no stuffing.
- data_in=8'hFF.
  - Required out_bit: 1,1,1,0,1,1,1,0,1,1,0,1,1,1,1.
  - 15 cycles, 2 stuffed zeros, done on the 15th.
- data_in=8'h00.
  - Required out_bit: eight 0s, then 0, then 1,1,1,1.
  - 13 cycles; the detector's output is high exactly once, on the 13th bit, and never earlier.
- Back-to-back: start held high with 8'hE7 then 8'h77.
  - Frame 1 bits: 1,1,1,0,0,0,1,1,1,0,1,1,1,1 (14 cycles).
  - Exactly one IDLE 0, then frame 2: 0,1,1,1,0,0,1,1,1,0,1,1,1,1.
  - start during busy has no effect.
- Reset asserted mid-DATA during an 8'hFF frame.
  - Next cycle out_bit=0, ready=1, busy=0, done never pulses.
  - A fresh 8'hA5 frame then transmits correctly.
- Randomised payloads through stuffed_frame_tx into the detector.
  - Required: exactly one detector pulse per frame, aligned with done.
  - De-stuffed payload equals data_in.
